// File: rtl/snoopy_pkg.sv
// snoopy_pkg
//   Shared constants and types for the Snoopy sprite plotter.
//   Screen geometry for the 160x120 VGA adapter, the 3-bit colour
//   constants, the default sprite size and the plotter state encoding.
package snoopy_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    // Coordinate widths needed to address every column / row of the screen.
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);

    localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b111;
    localparam logic [COLOUR_W-1:0] FG_COLOUR = 3'b000;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2
    } plot_state_e;

endpackage

// File: rtl/snoopy_sprite_rom.sv
// snoopy_sprite_rom
//   Combinational 1-bit sprite mask. A 1 means an opaque (foreground)
//   pixel, a 0 means a transparent pixel drawn in the background colour.
//   The default shape is a filled box with its four corner pixels cut off.
//   Kept combinational so the plotter's pixel latency does not depend on it.
// Ports:
//   addr_i  in   {row, col} of the pixel inside the sprite
//   mask_o  out  mask bit for that pixel
module snoopy_sprite_rom #(
    parameter int SPRITE_W = snoopy_pkg::SPRITE_W,
    parameter int SPRITE_H = snoopy_pkg::SPRITE_H,
    localparam int CW = $clog2(SPRITE_W),
    localparam int RW = $clog2(SPRITE_H)
) (
    input  logic [RW+CW-1:0] addr_i,
    output logic             mask_o
);
    import snoopy_pkg::*;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          edge_row;
    logic          edge_col;

    always_comb begin
        row      = addr_i[RW+CW-1:CW];
        col      = addr_i[CW-1:0];
        edge_row = (row == '0) || (row == RW'(SPRITE_H - 1));
        edge_col = (col == '0) || (col == CW'(SPRITE_W - 1));
        mask_o   = !(edge_row && edge_col);
    end

endmodule

// File: rtl/snoopy_sprite_plotter.sv
// snoopy_sprite_plotter
//   Once per frame, erases the previously drawn Snoopy box and redraws it
//   at the height given by snoopy_y, issuing one pixel write per cycle to
//   the 160x120 VGA adapter. Both boxes are walked in raster order.
//   Redraws at an unchanged height are skipped.
//
//   Handshake: vga_plot is a pure write strobe. The adapter takes a write
//   on every cycle vga_plot is high and never stalls, so there is no ready.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous, active-high reset
//   snoopy_y    in   height above ground (unsigned, upward positive)
//   frame_tick  in   one-cycle redraw request, ignored while busy
//   vga_x       out  pixel column (registered)
//   vga_y       out  pixel row (registered)
//   vga_colour  out  pixel colour (registered)
//   vga_plot    out  pixel write strobe (registered)
//   busy        out  erase/draw pass in progress (registered)
//   dbg_state   out  current FSM state, for observation only
module snoopy_sprite_plotter #(
    parameter int                                X_POS     = 20,
    parameter int                                SPRITE_W  = snoopy_pkg::SPRITE_W,
    parameter int                                SPRITE_H  = snoopy_pkg::SPRITE_H,
    parameter int                                BASE_ROW  = 119,
    parameter logic [snoopy_pkg::COLOUR_W-1:0]   BG_COLOUR = snoopy_pkg::BG_COLOUR,
    parameter logic [snoopy_pkg::COLOUR_W-1:0]   FG_COLOUR = snoopy_pkg::FG_COLOUR
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [7:0]                          snoopy_y,
    input  logic                                frame_tick,
    output logic [snoopy_pkg::XW-1:0]           vga_x,
    output logic [snoopy_pkg::YW-1:0]           vga_y,
    output logic [snoopy_pkg::COLOUR_W-1:0]     vga_colour,
    output logic                                vga_plot,
    output logic                                busy,
    output snoopy_pkg::plot_state_e             dbg_state
);
    import snoopy_pkg::*;

    localparam int CW   = $clog2(SPRITE_W);
    localparam int RW   = $clog2(SPRITE_H);
    // Highest top-row value: the sprite sits on the bottom edge.
    localparam int YMAX = BASE_ROW + 1 - SPRITE_H;

    plot_state_e         state_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [YW-1:0]       new_top_q;
    logic [YW-1:0]       drawn_top_q;
    logic                drawn_valid_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;
    logic                busy_q;

    logic [YW-1:0]       y_clamped;
    logic [YW-1:0]       new_top_d;
    logic [YW-1:0]       cur_top;
    logic [XW-1:0]       pix_x_d;
    logic [YW-1:0]       pix_y_d;
    logic [COLOUR_W-1:0] pix_colour_d;
    logic                mask_bit;
    logic                col_last;
    logic                pass_last;
    logic                same_as_drawn;

    // Every clamped top row fits in YW bits, so the subtraction is done
    // directly at that width; only the comparison needs all 8 input bits.
    always_comb begin
        y_clamped     = (snoopy_y > 8'(YMAX)) ? YW'(YMAX) : snoopy_y[YW-1:0];
        new_top_d     = YW'(YMAX) - y_clamped;
        same_as_drawn = drawn_valid_q && (new_top_d == drawn_top_q);
    end

    snoopy_sprite_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_rom (
        .addr_i ({row_q, col_q}),
        .mask_o (mask_bit)
    );

    always_comb begin
        cur_top      = (state_q == S_ERASE) ? drawn_top_q : new_top_q;
        pix_x_d      = XW'(X_POS) + XW'(col_q);
        pix_y_d      = cur_top + YW'(row_q);
        pix_colour_d = ((state_q == S_DRAW) && mask_bit) ? FG_COLOUR : BG_COLOUR;
        col_last     = (col_q == CW'(SPRITE_W - 1));
        pass_last    = col_last && (row_q == RW'(SPRITE_H - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            new_top_q     <= '0;
            drawn_top_q   <= '0;
            drawn_valid_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= BG_COLOUR;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    col_q  <= '0;
                    row_q  <= '0;
                    if (frame_tick) begin
                        new_top_q <= new_top_d;
                    end
                    if (frame_tick && !same_as_drawn) begin
                        busy_q  <= 1'b1;
                        state_q <= drawn_valid_q ? S_ERASE : S_DRAW;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end

                S_ERASE, S_DRAW: begin
                    x_q      <= pix_x_d;
                    y_q      <= pix_y_d;
                    colour_q <= pix_colour_d;
                    plot_q   <= 1'b1;
                    busy_q   <= 1'b1;
                    if (pass_last) begin
                        col_q <= '0;
                        row_q <= '0;
                        if (state_q == S_ERASE) begin
                            state_q <= S_DRAW;
                        end else begin
                            drawn_top_q   <= new_top_q;
                            drawn_valid_q <= 1'b1;
                            state_q       <= S_IDLE;
                        end
                    end else if (col_last) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule
